// File: rtl/avalon_multi_timer.sv
// avalon_multi_timer
//   Multi-channel down-counting interval timer on an Avalon-MM slave port.
//   Each channel has an eight-word register window at {channel, reg[2:0]}:
//     0 status   {RUN, TO}            (any write clears TO)
//     1 control  {PWM_EN, STOP, START, CONT, ITO} bits 4..0 (START/STOP read 0)
//     2/3 period low/high, 4/5 snapshot low/high, 6/7 compare low/high
//   Optional feature macro: TIMER_PWM_EN (compare registers, PWM_EN, pwm_out).
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   address     {channel, reg[2:0]} word address
//   chipselect  slave select
//   write_n     active-low write strobe, qualified by chipselect
//   writedata   16-bit write data
//   readdata    16-bit registered read data (one-cycle latency, always updated)
//   irq         OR over channels of (TO & ITO)
//   pwm_out     per-channel registered compare output
module avalon_multi_timer #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 32,
    parameter int RESET_PERIOD = 49999
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [2+$clog2(NUM_CH):0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [15:0]                 writedata,
    output logic [15:0]                 readdata,
    output logic                        irq,
    output logic [NUM_CH-1:0]           pwm_out
);

    // Replace one 16-bit half of a CNT_W-bit register; bits at or above
    // CNT_W fall off when the 32-bit scratch value is truncated.
    function automatic logic [CNT_W-1:0] merge_half(input logic [CNT_W-1:0] cur,
                                                    input logic [15:0] wd,
                                                    input logic hi);
        logic [31:0] t;
        t = 32'(cur);
        if (hi) t[31:16] = wd;
        else    t[15:0]  = wd;
        return t[CNT_W-1:0];
    endfunction

    // Extract one 16-bit half; missing upper bits read as zero.
    function automatic logic [15:0] read_half(input logic [CNT_W-1:0] v, input logic hi);
        logic [31:0] t;
        t = 32'(v);
        return hi ? t[31:16] : t[15:0];
    endfunction

    logic                     wr;
    logic [31:0]              ch_num;
    logic [2:0]               reg_sel;
    logic [NUM_CH-1:0][15:0]  ch_rd;
    logic [NUM_CH-1:0]        irq_ch;
    logic [NUM_CH-1:0]        pwm_ch;
    logic [15:0]              rd_next;

    assign wr      = chipselect && !write_n;
    assign ch_num  = 32'(address) >> 3;
    assign reg_sel = address[2:0];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] counter;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] snapshot;
        logic             run;
        logic             to;
        logic             ito;
        logic             cont;
        logic             zero;
        logic             zero_d;
        logic             load_pend;
        logic             we;
        logic [15:0]      rd_val;
        logic [CNT_W-1:0] compare;
        logic             pwm_en;

        assign we = wr && (ch_num == 32'(g));
        // Zero is qualified by RUN so each START of a period-0 or one-shot
        // channel produces a fresh rising edge, and a stopped channel never
        // raises TO.
        assign zero = run && (counter == '0);

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                counter   <= CNT_W'(RESET_PERIOD);
                period    <= CNT_W'(RESET_PERIOD);
                snapshot  <= '0;
                run       <= 1'b0;
                to        <= 1'b0;
                ito       <= 1'b0;
                cont      <= 1'b0;
                zero_d    <= 1'b0;
                load_pend <= 1'b0;
            end else begin
                zero_d    <= zero;
                load_pend <= 1'b0;

                if (load_pend) begin
                    counter <= period;
                end else if (run) begin
                    if (counter == '0) begin
                        counter <= period;
                        if (!cont) run <= 1'b0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end

                if (zero && !zero_d) to <= 1'b1;

                // Bus writes come last so they take priority: status clear
                // beats a TO set, START beats an automatic one-shot stop.
                if (we) begin
                    case (reg_sel)
                        3'd0: to <= 1'b0;
                        3'd1: begin
                            ito  <= writedata[0];
                            cont <= writedata[1];
                            if (writedata[2])      run <= 1'b1;
                            else if (writedata[3]) run <= 1'b0;
                        end
                        3'd2, 3'd3: begin
                            period    <= merge_half(period, writedata, reg_sel[0]);
                            run       <= 1'b0;
                            load_pend <= 1'b1;
                        end
                        3'd4, 3'd5: snapshot <= counter;
                        default: ;
                    endcase
                end
            end
        end

`ifdef TIMER_PWM_EN
        logic pwm_q;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                compare <= '0;
                pwm_en  <= 1'b0;
                pwm_q   <= 1'b0;
            end else begin
                pwm_q <= run && pwm_en && (counter < compare);
                if (we && reg_sel == 3'd1) pwm_en <= writedata[4];
                if (we && (reg_sel == 3'd6 || reg_sel == 3'd7))
                    compare <= merge_half(compare, writedata, reg_sel[0]);
            end
        end

        assign pwm_ch[g] = pwm_q;
`else
        assign compare   = '0;
        assign pwm_en    = 1'b0;
        assign pwm_ch[g] = 1'b0;
`endif

        always_comb begin
            rd_val = '0;
            case (reg_sel)
                3'd0:       rd_val = {14'd0, run, to};
                3'd1:       rd_val = {11'd0, pwm_en, 2'b00, cont, ito};
                3'd2, 3'd3: rd_val = read_half(period, reg_sel[0]);
                3'd4, 3'd5: rd_val = read_half(snapshot, reg_sel[0]);
                default:    rd_val = read_half(compare, reg_sel[0]);
            endcase
        end

        assign ch_rd[g]  = rd_val;
        assign irq_ch[g] = to && ito;
    end

    // Channels beyond NUM_CH match no entry and read zero.
    always_comb begin
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_num == 32'(c)) rd_next = ch_rd[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_next;
    end

    assign irq     = |irq_ch;
    assign pwm_out = pwm_ch;

endmodule

// File: doc/avalon_multi_timer.md
AVALON_MULTI_TIMER -- requirements
Module: avalon_multi_timer

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent timer channels (1..4).
REQ-002 Parameter CNT_W, default 32: counter width per channel (16..32).
REQ-003 Parameter RESET_PERIOD, default 49999: per-channel period and counter value after reset.
REQ-004 Port clk  input  1  sole clock; all logic on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port address  input  3+clog2(NUM_CH)  {channel, reg[2:0]} word address.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-009 Port writedata  input  16  write data.
REQ-010 Port readdata  output  16  registered read data.
REQ-011 Port irq  output  1  OR over channels of (TO & ITO).
REQ-012 Port pwm_out  output  NUM_CH  per-channel compare output.

Function
REQ-013 Per-channel register map: 0 status {RUN,TO}; 1 control {PWM_EN,STOP,START,CONT,ITO} bits 4..0; 2/3 period low/high; 4/5 snapshot low/high; 6/7 compare low/high.
REQ-014 Write = chipselect & ~write_n; readdata SHALL be updated every cycle from the addressed register, one-cycle latency, independent of chipselect.
REQ-015 Channel index >= NUM_CH SHALL read 0 and ignore writes.
REQ-016 Period, snapshot and compare bits at or above CNT_W SHALL read 0 and ignore writes.
REQ-017 Running counter SHALL decrement by 1 per cycle; at 0 it SHALL reload period on the next cycle.
REQ-018 At 0 with CONT=0, RUN SHALL clear in the same cycle the reload occurs; with CONT=1, RUN stays set.
REQ-019 TO SHALL set on the cycle after the counter first becomes 0 (rising edge of is-zero); any write to status clears TO, and clear wins over a simultaneous set.
REQ-020 Control write with START=1 sets RUN; with STOP=1 clears RUN; both set: START wins; START/STOP are not stored (read 0).
REQ-021 Period write (either half) SHALL, on the following cycle, load the counter with the new period and clear RUN unless START is written the same cycle.
REQ-022 Write to snapshot low or high SHALL capture the full counter value into the snapshot register.
REQ-023 Period of 0: counter stays 0; TO sets once per START; no wrap below 0.
REQ-024 pwm_out[ch] = RUN & PWM_EN & (counter < compare), registered; compare 0 -> constant low, compare > period -> constant high while running.
REQ-025 Channels SHALL be fully independent; simultaneous events on different channels SHALL not interact except via irq OR.

Reset
REQ-026 On reset_n low: counter=period=RESET_PERIOD, control=0, RUN=0, TO=0, snapshot=0, compare=0, readdata=0, irq=0, pwm_out=0.
REQ-027 Reset mid-count SHALL abort immediately; no TO or irq pulse follows deassertion.

Configuration
REQ-028 Macro TIMER_PWM_EN defined: compare registers, PWM_EN bit and pwm_out active per REQ-024.
REQ-029 TIMER_PWM_EN undefined: compare and PWM_EN read 0, writes ignored, pwm_out tied 0, no compare logic synthesised.

Verification
REQ-030 Reset, read ch0 period low -> 49999 (0xC34F) two cycles later; irq=0, pwm_out=0.
REQ-031 Ch0 period=9, control=0x07 (ITO,CONT,START) -> TO and irq every 10 cycles; status write clears irq next cycle.
REQ-032 Ch1 period=4, control=0x04 (one-shot) -> single TO, RUN=0 after reload, counter holds 4; ch0 unaffected.
REQ-033 Ch0 running from period 100, snapshot write after 30 cycles -> snapshot reads 70 +/-1 per documented latency, constant across repeated reads.
REQ-034 TIMER_PWM_EN, ch0 period=9, compare=3, control=0x16 -> pwm_out[0] high 3 of every 10 cycles; compare=0 -> always low.
REQ-035 Control write 0x0C (START+STOP) while stopped -> RUN=1; period write during run -> RUN=0, counter=new period.
